// File: rtl/cp0_irq_pkg.sv
// Shared CP0 constants: register numbers, SR bit positions and reset values.
package cp0_irq_pkg;

   localparam int unsigned NUM_HW = 6;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam int unsigned IM_HI   = 15;
   localparam int unsigned IM_LO   = 10;
   localparam int unsigned EXL_BIT = 1;
   localparam int unsigned IE_BIT  = 0;

   localparam logic [31:0] RST_SR  = 32'h0000_0000;
   localparam logic [31:0] RST_EPC = 32'h0000_0000;

endpackage

// File: rtl/cp0_irq_if.sv
// CPU-side bundle for the CP0 interrupt responder: mfc0/mtc0 access, commit PC,
// eret strobe, device lines in, and read data / EPC / interrupt request out.
interface cp0_irq_if;
   import cp0_irq_pkg::*;

   logic [NUM_HW-1:0] HWINT_I;
   logic [29:0]       PC_I;
   logic [4:0]        SEL_I;
   logic              WE_I;
   logic [31:0]       DAT_I;
   logic              ERET_I;
   logic [31:0]       DAT_O;
   logic [31:0]       EPC_O;
   logic              IRQ_O;

   modport master (
      output HWINT_I, PC_I, SEL_I, WE_I, DAT_I, ERET_I,
      input  DAT_O, EPC_O, IRQ_O
   );

   modport slave (
      input  HWINT_I, PC_I, SEL_I, WE_I, DAT_I, ERET_I,
      output DAT_O, EPC_O, IRQ_O
   );

endinterface

// File: rtl/cp0_irq.sv
// Coprocessor-0 interrupt responder: SR/Cause/EPC/PrID, one-stage IRQ line
// synchroniser, interrupt entry (EPC capture, EXL set) and ERET (EXL clear).
module cp0_irq
   import cp0_irq_pkg::*;
#(
   parameter logic [31:0] PRID     = 32'h0000_C5C5,
   parameter int unsigned HW_LINES = 6
) (
   input logic       CLK_I,
   input logic       RST_I,
   cp0_irq_if.slave  bus
);

   logic [HW_LINES-1:0] ip_q;
   logic [HW_LINES-1:0] im_q, im_d;
   logic                exl_q, exl_d;
   logic                ie_q, ie_d;
   logic [29:0]         epc_q, epc_d;
   logic                irq;
   logic [31:0]         sr_word;
   logic [31:0]         cause_word;

   // Interrupt request: any enabled pending line, globally enabled, not in a handler.
   always_comb begin
      irq = (|(ip_q & im_q)) & ie_q & ~exl_q;
   end

   // Next-state: entry wins over everything; else mtc0 first, then eret clears EXL.
   always_comb begin
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      epc_d = epc_q;
      if (irq) begin
         // Instruction at PC_I is squashed, so its mtc0/eret is discarded.
         epc_d = bus.PC_I;
         exl_d = 1'b1;
      end else begin
         if (bus.WE_I && (bus.SEL_I == REG_SR)) begin
            im_d  = bus.DAT_I[IM_HI:IM_LO];
            exl_d = bus.DAT_I[EXL_BIT];
            ie_d  = bus.DAT_I[IE_BIT];
         end
         if (bus.WE_I && (bus.SEL_I == REG_EPC)) begin
            epc_d = bus.DAT_I[31:2];
         end
         if (bus.ERET_I) begin
            exl_d = 1'b0;
         end
      end
   end

   // State registers; IP simply resamples the device lines every cycle.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ip_q  <= '0;
         im_q  <= RST_SR[IM_HI:IM_LO];
         exl_q <= RST_SR[EXL_BIT];
         ie_q  <= RST_SR[IE_BIT];
         epc_q <= RST_EPC[31:2];
      end else begin
         ip_q  <= bus.HWINT_I;
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         epc_q <= epc_d;
      end
   end

   // Assemble the architectural views of SR and Cause; unused bits read 0.
   always_comb begin
      sr_word                = '0;
      sr_word[IM_HI:IM_LO]   = im_q;
      sr_word[EXL_BIT]       = exl_q;
      sr_word[IE_BIT]        = ie_q;
      cause_word             = '0;
      cause_word[IM_HI:IM_LO] = ip_q;
   end

   // mfc0 read mux, combinational from SEL_I with no write bypass.
   always_comb begin
      case (bus.SEL_I)
         REG_SR:    bus.DAT_O = sr_word;
         REG_CAUSE: bus.DAT_O = cause_word;
         REG_EPC:   bus.DAT_O = {epc_q, 2'b00};
         REG_PRID:  bus.DAT_O = PRID;
         default:   bus.DAT_O = 32'h0000_0000;
      endcase
   end

   // Outputs to the pipeline.
   always_comb begin
      bus.EPC_O = {epc_q, 2'b00};
      bus.IRQ_O = irq;
   end

endmodule
